mem_port_arbiter: RTL

- Shares one memory port between two requesters: requester 0 is instruction fetch and requester 1 is data load/store.
- Steers address, write-data and write-enable through the team's 2-input width-parameterised select muxes.
- Runs a round-robin FSM with a req/done handshake.
- Sits between the fetch/LSU stages and the unified memory model in the multicycle core.

---
 rtl/arb_pkg.sv | 16 +
 rtl/MUX_2.sv | 15 +
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and port-owner codes.
// No ports; this package is imported by mem_port_arbiter.
// Owner codes double as the select value of the steering muxes.
package arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_0 = 2'd1,
      ST_BUSY_1 = 2'd2
   } arb_state_e;

   // Owner of the memory port; also the mux select value.
   localparam logic OWN_IF  = 1'b0;   // instruction fetch (requester 0)
   localparam logic OWN_MEM = 1'b1;   // data load/store (requester 1)

endpackage

// File: rtl/MUX_2.sv
// Generic 2-input select mux, width-parameterised.
// Ports: In_0 / In_1 data inputs, In_Sel select (1 picks In_1), Out_Data result.
// Purely combinational: zero latency, no flow control.
module MUX_2 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] In_0,
   input  logic [WIDTH-1:0] In_1,
   input  logic             In_Sel,
   output logic [WIDTH-1:0] Out_Data
);

   assign Out_Data = In_Sel ? In_1 : In_0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (req 0, read-only) and load/store (req 1).
// Latency: grant registered one cycle after req is seen; done_x is combinational on mem_ready (min 2 cycles).
// Backpressure: requesters hold req until done_x; memory stalls the busy state by holding mem_ready low.
// Ports: req_x/addr_x (+ we_1/wdata_1) from requesters, done_x/rdata back; mem_* to the memory model;
//        sel is the current owner; err is a timeout abort pulse.
// Optional feature: define ARB_TIMEOUT_EN to abort a busy state after TIMEOUT cycles without mem_ready.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_0,
   input  logic [ADDR_WIDTH-1:0] addr_0,
   input  logic                  req_1,
   input  logic [ADDR_WIDTH-1:0] addr_1,
   input  logic                  we_1,
   input  logic [WIDTH-1:0]      wdata_1,
   output logic                  done_0,
   output logic                  done_1,
   output logic [WIDTH-1:0]      rdata,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_ready,
   output logic                  sel,
   output logic                  err
);

   // A limit below 2 would leave no cycle for the memory to answer.
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT must be at least 2");
   end

   arb_state_e state_q;
   logic       sel_q;
   logic       last_q;      // owner of the most recent completed/aborted access
   logic       mem_req_q;
   logic       busy;
   logic       abort;

   assign busy = (state_q == ST_BUSY_0) || (state_q == ST_BUSY_1);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] cnt_q;

   // mem_ready on the limit cycle wins over the abort.
   assign abort = busy && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign abort = 1'b0;
`endif

   assign err = abort;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         sel_q     <= OWN_IF;
         last_q    <= OWN_MEM;   // requester 0 wins the first tie
         mem_req_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Requester 0 wins if alone, or in a tie when requester 1 went last.
               if (req_0 && (!req_1 || (last_q == OWN_MEM))) begin
                  state_q   <= ST_BUSY_0;
                  sel_q     <= OWN_IF;
                  mem_req_q <= 1'b1;
               end else if (req_1) begin
                  state_q   <= ST_BUSY_1;
                  sel_q     <= OWN_MEM;
                  mem_req_q <= 1'b1;
               end
`ifdef ARB_TIMEOUT_EN
               cnt_q <= '0;
`endif
            end
            ST_BUSY_0, ST_BUSY_1: begin
               // Completion and abort both return through IDLE, giving the one-cycle bubble.
               if (mem_ready || abort) begin
                  last_q    <= sel_q;
                  state_q   <= ST_IDLE;
                  mem_req_q <= 1'b0;
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign sel     = sel_q;
   assign mem_req = mem_req_q;
   assign done_0  = (state_q == ST_BUSY_0) && mem_ready;
   assign done_1  = (state_q == ST_BUSY_1) && mem_ready;
   assign rdata   = mem_rdata;

   MUX_2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
      .In_0     (addr_0),
      .In_1     (addr_1),
      .In_Sel   (sel_q),
      .Out_Data (mem_addr)
   );

   // Requester 0 never writes, so its data leg is zero.
   MUX_2 #(.WIDTH(WIDTH)) u_wdata_mux (
      .In_0     ('0),
      .In_1     (wdata_1),
      .In_Sel   (sel_q),
      .Out_Data (mem_wdata)
   );

   MUX_2 #(.WIDTH(1)) u_we_mux (
      .In_0     (1'b0),
      .In_1     (we_1),
      .In_Sel   (sel_q),
      .Out_Data (mem_we)
   );

endmodule
